// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package regfile_pkg;

  typedef enum logic {GRANT_A, GRANT_B} grant_t;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter. Bit 0 is requester A, bit 1 is requester B.
// Priority only rotates when both requested and a transfer was accepted.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  grant_t last_grant_reg;
  grant_t last_grant_next;

  // Last-grant register; after reset B counts as last winner so A wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_reg <= GRANT_B;
    else     last_grant_reg <= last_grant_next;
  end

  // Grant selection and priority rotation; grants are suppressed during reset.
  always_comb begin
    gnt             = 2'b00;
    last_grant_next = last_grant_reg;
    if (!rst) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant_reg == GRANT_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
      if (accept && req == 2'b11)
        last_grant_next = gnt[0] ? GRANT_A : GRANT_B;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU (A) and load (B)
// writeback paths, tracks outstanding writes per register, and counts
// cycles in which both paths competed.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH    = REG_DATA_W,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          a_valid,
  input  logic [ADDRESS_WIDTH-1:0]      a_addr,
  input  logic [DATA_WIDTH-1:0]         a_data,
  output logic                          a_ready,
  input  logic                          b_valid,
  input  logic [ADDRESS_WIDTH-1:0]      b_addr,
  input  logic [DATA_WIDTH-1:0]         b_data,
  output logic                          b_ready,
  input  logic                          iss_valid,
  input  logic [ADDRESS_WIDTH-1:0]      iss_addr,
  output logic                          we3,
  output logic [ADDRESS_WIDTH-1:0]      ad3,
  output logic [DATA_WIDTH-1:0]         wd3,
  output logic [2**ADDRESS_WIDTH-1:0]   pending,
  output logic [CNT_WIDTH-1:0]          conflict_cnt
);

  localparam int REG_COUNT = 2**ADDRESS_WIDTH;

  logic [1:0]               req;
  logic [1:0]               gnt;
  logic                     transfer;
  logic [ADDRESS_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0]    win_data;

  logic                     we3_reg;
  logic [ADDRESS_WIDTH-1:0] ad3_reg;
  logic [DATA_WIDTH-1:0]    wd3_reg;
  logic [CNT_WIDTH-1:0]     conflict_cnt_reg;

  assign req = {b_valid, a_valid};

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (transfer),
    .gnt    (gnt)
  );

  assign a_ready  = gnt[0];
  assign b_ready  = gnt[1];
  assign transfer = |(gnt & req);

  // Mux the winning requester onto the write path.
  always_comb begin
    win_addr = a_addr;
    win_data = a_data;
    if (gnt[1]) begin
      win_addr = b_addr;
      win_data = b_data;
    end
  end

  // Registered write port; address 0 consumes the grant but never writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3_reg <= 1'b0;
      ad3_reg <= '0;
      wd3_reg <= '0;
    end else if (transfer) begin
      we3_reg <= (win_addr != '0);
      ad3_reg <= win_addr;
      wd3_reg <= win_data;
    end else begin
      we3_reg <= 1'b0;
    end
  end

  assign we3 = we3_reg;
  assign ad3 = ad3_reg;
  assign wd3 = wd3_reg;

  // Pending scoreboard: one flop per register, register 0 is hardwired clear.
  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_pending
      if (gi == 0) begin : g_zero
        assign pending[gi] = 1'b0;
      end else begin : g_bit
        logic bit_reg;
        logic set_hit;
        logic clr_hit;
        assign set_hit = iss_valid && (iss_addr == ADDRESS_WIDTH'(gi));
        assign clr_hit = transfer && (win_addr == ADDRESS_WIDTH'(gi));
        // A new issue takes precedence over a writeback to the same register.
        always_ff @(posedge clk or posedge rst) begin
          if (rst)          bit_reg <= 1'b0;
          else if (set_hit) bit_reg <= 1'b1;
          else if (clr_hit) bit_reg <= 1'b0;
        end
        assign pending[gi] = bit_reg;
      end
    end
  endgenerate

  // Saturating count of cycles where both requesters were valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict_cnt_reg <= '0;
    else if (a_valid && b_valid && conflict_cnt_reg != '1)
      conflict_cnt_reg <= conflict_cnt_reg + CNT_WIDTH'(1);
  end

  assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (counter narrowed to 4 bits).
module tb_regfile_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, iss_valid;
  logic [AW-1:0] a_addr, b_addr, iss_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, we3;
  logic [AW-1:0] ad3;
  logic [DW-1:0] wd3;
  logic [31:0]   pending;
  logic [CW-1:0] conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .iss_valid    (iss_valid),
    .iss_addr     (iss_addr),
    .we3          (we3),
    .ad3          (ad3),
    .wd3          (wd3),
    .pending      (pending),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; b_valid = 0; iss_valid = 0;
    a_addr = '0; b_addr = '0; iss_addr = '0;
    a_data = '0; b_data = '0;

    // Reset: outputs clear, ready suppressed even with a request present.
    #12;
    a_valid = 1'b1;
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_we3", we3, 0);
    chk("rst_pending", pending, 0);
    a_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) step();
    chk("idle_we3", we3, 0);
    chk("idle_pending", pending, 0);
    chk("idle_cnt", conflict_cnt, 0);

    // Lone A write.
    a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    #1;
    chk("lone_a_ready", a_ready, 1);
    chk("lone_b_ready", b_ready, 0);
    step();
    a_valid = 0;
    chk("lone_we3", we3, 1);
    chk("lone_ad3", ad3, 5);
    chk("lone_wd3", wd3, 32'hDEADBEEF);
    step();
    chk("lone_idle_we3", we3, 0);
    chk("lone_hold_ad3", ad3, 5);

    // Contention: A wins first (lone A did not rotate), then alternate.
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_addr = 1; a_data = 32'h100 + i;
      b_valid = 1; b_addr = 2; b_data = 32'h200 + i;
      #1;
      chk($sformatf("rr%0d_a_ready", i), a_ready, (i % 2 == 0));
      chk($sformatf("rr%0d_b_ready", i), b_ready, (i % 2 == 1));
      step();
      chk($sformatf("rr%0d_ad3", i), ad3, (i % 2 == 0) ? 1 : 2);
      chk($sformatf("rr%0d_wd3", i), wd3, (i % 2 == 0) ? 32'h100 + i : 32'h200 + i);
      chk($sformatf("rr%0d_we3", i), we3, 1);
    end
    a_valid = 0; b_valid = 0;
    chk("rr_cnt", conflict_cnt, 4);

    // B write to register 0: granted but no write enable.
    b_valid = 1; b_addr = 0; b_data = 32'h1234;
    #1;
    chk("z_b_ready", b_ready, 1);
    step();
    b_valid = 0;
    chk("z_we3", we3, 0);
    chk("z_wd3", wd3, 32'h1234);
    chk("z_pending", pending, 0);

    // Issue to register 0 never marks pending.
    iss_valid = 1; iss_addr = 0;
    step();
    chk("iss0_pending", pending, 0);

    // Scoreboard set / set-wins / clear.
    iss_valid = 1; iss_addr = 7;
    step();
    chk("iss7_pending", pending, 32'h80);
    a_valid = 1; a_addr = 7; a_data = 32'h77;
    step();
    chk("setwins_pending", pending, 32'h80);
    chk("setwins_ad3", ad3, 7);
    iss_valid = 0;
    step();
    a_valid = 0;
    chk("clr7_pending", pending, 0);
    a_valid = 1; a_addr = 3; a_data = 32'h33;
    step();
    a_valid = 0;
    chk("clr_clear_pending", pending, 0);

    // Saturation: 4 + 19 conflict cycles clamp at 4'hF.
    a_valid = 1; a_addr = 4; a_data = 32'h4;
    b_valid = 1; b_addr = 6; b_data = 32'h6;
    repeat (10) step();
    chk("sat_mid_cnt", conflict_cnt, 4'hE);
    repeat (9) step();
    a_valid = 0; b_valid = 0;
    chk("sat_cnt", conflict_cnt, 4'hF);
    step();
    chk("sat_hold_cnt", conflict_cnt, 4'hF);

    // Asynchronous reset mid-cycle drops an in-flight write.
    iss_valid = 1; iss_addr = 12;
    step();
    iss_valid = 0;
    a_valid = 1; a_addr = 9; a_data = 32'h99;
    step();
    a_valid = 0;
    chk("pre_rst_we3", we3, 1);
    chk("pre_rst_pending", pending, 32'h1000);
    #2;
    rst = 1;
    #1;
    chk("async_we3", we3, 0);
    chk("async_ad3", ad3, 0);
    chk("async_pending", pending, 0);
    chk("async_cnt", conflict_cnt, 0);
    @(negedge clk);
    rst = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
